// File: rtl/sle_pkg.sv
// Shared definitions for the SLE register pipeline: per-edge operation decode
// and the occupancy-counter width helper.
package sle_pkg;

    typedef enum logic [1:0] {
        OP_FLUSH = 2'd0,
        OP_HOLD  = 2'd1,
        OP_LOAD  = 2'd2,
        OP_SHIFT = 2'd3
    } sle_op_e;

    function automatic int CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Flush beats the stall, the stall beats the preset load, shifting is the fallback.
    function automatic sle_op_e decode_op(input logic flush, input logic en, input logic sln);
        if (flush)
            return OP_FLUSH;
        else if (!en)
            return OP_HOLD;
        else if (!sln)
            return OP_LOAD;
        else
            return OP_SHIFT;
    endfunction

endpackage

// File: rtl/sle_stage.sv
// One WIDTH-bit SLE-style stage: data register with preset load, plus a valid
// bit that can be flushed independently of the data.
module sle_stage
    import sle_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  sle_op_e          op,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sd,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] data_d;
    logic             valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        case (op)
            OP_FLUSH: valid_d = 1'b0;
            OP_LOAD: begin
                data_d  = sd;
                valid_d = 1'b0;
            end
            OP_SHIFT: begin
                data_d  = d;
                valid_d = in_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/sle_pipe.sv
// DEPTH-deep stallable, presettable, flushable register chain with per-stage
// valid tracking and a registered occupancy count.
module sle_pipe
    import sle_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           d,
    input  logic                       in_valid,
    input  logic                       en,
    input  logic                       sln,
    input  logic [WIDTH-1:0]           sd,
    input  logic                       flush,
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    output logic [CNT_W(DEPTH)-1:0]    count
);

    localparam int CW = CNT_W(DEPTH);

    sle_op_e                      op;
    logic [DEPTH-1:0][WIDTH-1:0]  stage_data;
    logic [DEPTH-1:0]             stage_valid;
    logic [CW-1:0]                count_q;
    logic [CW-1:0]                count_d;

    assign op = decode_op(flush, en, sln);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] prev_data;
            logic             prev_valid;

            if (gi == 0) begin : g_head
                assign prev_data  = d;
                assign prev_valid = in_valid;
            end else begin : g_body
                assign prev_data  = stage_data[gi-1];
                assign prev_valid = stage_valid[gi-1];
            end

            sle_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .op       (op),
                .d        (prev_data),
                .in_valid (prev_valid),
                .sd       (sd),
                .data_q   (stage_data[gi]),
                .valid_q  (stage_valid[gi])
            );
        end
    endgenerate

    // Counter tracks the valid bits incrementally: one enters, the tail one leaves.
    always_comb begin
        count_d = count_q;
        case (op)
            OP_FLUSH, OP_LOAD: count_d = '0;
            OP_SHIFT: count_d = count_q + CW'(in_valid) - CW'(stage_valid[DEPTH-1]);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign q         = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_sle_pipe.sv
// Self-checking bench for sle_pipe: directed vector table, reset and random
// sequences compared against an array-based behavioural model.
module tb_sle_pipe;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       in_valid;
    logic       en;
    logic       sln;
    logic [7:0] sd;
    logic       flush;
    logic [7:0] q;
    logic       out_valid;
    logic [2:0] count;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] m_data  [DEPTH];
    logic       m_valid [DEPTH];

    sle_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .in_valid  (in_valid),
        .en        (en),
        .sln       (sln),
        .sd        (sd),
        .flush     (flush),
        .q         (q),
        .out_valid (out_valid),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       iv;
        logic       en;
        logic       sln;
        logic [7:0] sd;
        logic       flush;
        logic [7:0] exp_q;
        logic       exp_ov;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs [20];

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_data[k]  = RST_VAL;
            m_valid[k] = 1'b0;
        end
    endtask

    // Reference behaviour of one rising edge, written straight from the priority rules.
    task automatic model_edge();
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
        end else if (!en) begin
        end else if (!sln) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_data[k]  = sd;
                m_valid[k] = 1'b0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_data[k]  = m_data[k-1];
                m_valid[k] = m_valid[k-1];
            end
            m_data[0]  = d;
            m_valid[0] = in_valid;
        end
    endtask

    function automatic logic [2:0] model_count();
        int c = 0;
        for (int k = 0; k < DEPTH; k++) c += int'(m_valid[k]);
        return 3'(c);
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic apply(input logic [7:0] i_d, input logic i_iv, input logic i_en,
                         input logic i_sln, input logic [7:0] i_sd, input logic i_flush);
        d = i_d; in_valid = i_iv; en = i_en; sln = i_sln; sd = i_sd; flush = i_flush;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic add_vec(input int i, input logic [7:0] vd, input logic viv, input logic ven,
                           input logic vsln, input logic [7:0] vsd, input logic vfl,
                           input logic [7:0] eq, input logic eov, input logic [2:0] ec);
        vecs[i] = '{vd, viv, ven, vsln, vsd, vfl, eq, eov, ec};
    endtask

    initial begin
        // streaming from reset: 01 reaches q on the 4th edge
        add_vec(0,  8'h01, 1, 1, 1, 8'h00, 0, 8'hA5, 0, 3'd1);
        add_vec(1,  8'h02, 1, 1, 1, 8'h00, 0, 8'hA5, 0, 3'd2);
        add_vec(2,  8'h03, 1, 1, 1, 8'h00, 0, 8'hA5, 0, 3'd3);
        add_vec(3,  8'h04, 1, 1, 1, 8'h00, 0, 8'h01, 1, 3'd4);
        add_vec(4,  8'h05, 1, 1, 1, 8'h00, 0, 8'h02, 1, 3'd4);
        // stall holds everything; then a bubble shifts in and a valid leaves
        add_vec(5,  8'h66, 1, 0, 1, 8'h00, 0, 8'h02, 1, 3'd4);
        add_vec(6,  8'h66, 1, 0, 1, 8'h00, 0, 8'h02, 1, 3'd4);
        add_vec(7,  8'h06, 0, 1, 1, 8'h00, 0, 8'h03, 1, 3'd3);
        // synchronous preset load, then load attempt while stalled
        add_vec(8,  8'h07, 1, 1, 0, 8'h3C, 0, 8'h3C, 0, 3'd0);
        add_vec(9,  8'h08, 1, 0, 0, 8'h77, 0, 8'h3C, 0, 3'd0);
        // 10..13 with a 3-cycle stall: 10 arrives on the 4th enabled edge
        add_vec(10, 8'h10, 1, 1, 1, 8'h00, 0, 8'h3C, 0, 3'd1);
        add_vec(11, 8'h11, 1, 1, 1, 8'h00, 0, 8'h3C, 0, 3'd2);
        add_vec(12, 8'h12, 1, 1, 1, 8'h00, 0, 8'h3C, 0, 3'd3);
        add_vec(13, 8'h99, 1, 0, 1, 8'h00, 0, 8'h3C, 0, 3'd3);
        add_vec(14, 8'h99, 1, 0, 1, 8'h00, 0, 8'h3C, 0, 3'd3);
        add_vec(15, 8'h99, 1, 0, 1, 8'h00, 0, 8'h3C, 0, 3'd3);
        add_vec(16, 8'h13, 1, 1, 1, 8'h00, 0, 8'h10, 1, 3'd4);
        // flush beats a stalled load: data kept, valids cleared
        add_vec(17, 8'hEE, 1, 0, 0, 8'hFF, 1, 8'h10, 0, 3'd0);
        // flush beats an enabled load too
        add_vec(18, 8'hEE, 1, 1, 0, 8'hFF, 1, 8'h10, 0, 3'd0);
        add_vec(19, 8'h20, 1, 1, 1, 8'h00, 0, 8'h11, 0, 3'd1);

        rst = 1'b1; d = '0; in_valid = 0; en = 0; sln = 1; sd = '0; flush = 0;
        model_reset();
        #3;
        check("rst_q", 0, q, RST_VAL);
        check("rst_ov", 0, {7'd0, out_valid}, 8'd0);
        check("rst_cnt", 0, {5'd0, count}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i].d, vecs[i].iv, vecs[i].en, vecs[i].sln, vecs[i].sd, vecs[i].flush);
            check("vec_q", i, q, vecs[i].exp_q);
            check("vec_ov", i, {7'd0, out_valid}, {7'd0, vecs[i].exp_ov});
            check("vec_cnt", i, {5'd0, count}, {5'd0, vecs[i].exp_cnt});
        end

        // mid-cycle asynchronous reset with a full pipeline
        for (int i = 0; i < DEPTH; i++) apply(8'h40 + 8'(i), 1, 1, 1, 8'h00, 0);
        check("full_cnt", 0, {5'd0, count}, 8'd4);
        #2 rst = 1'b1;
        #1;
        check("async_q", 0, q, RST_VAL);
        check("async_ov", 0, {7'd0, out_valid}, 8'd0);
        check("async_cnt", 0, {5'd0, count}, 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            apply(8'($urandom), 1'($urandom), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) != 0), 8'($urandom), ($urandom_range(0, 19) == 0));
            check("rnd_q", i, q, m_data[DEPTH-1]);
            check("rnd_ov", i, {7'd0, out_valid}, {7'd0, m_valid[DEPTH-1]});
            check("rnd_cnt", i, {5'd0, count}, {5'd0, model_count()});
            n_vec++;
            assert (count == 3'($countones(dut.stage_valid))) else begin
                n_bad++;
                $display("FAIL popcount[%0d]: count %0d valids %b", i, count, dut.stage_valid);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
